// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source side of a two-phase toggle req/ack CDC link
// Optional feature macro: CDC_TX_TIMEOUT_EN (wait-state timeout counter and sticky timeout_err)
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGE     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  proto_err,
  output logic                  timeout_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [SYNC_STAGE-1:0] ack_sync_q;
  logic                  ack_sync;
  logic                  accept;

  // Plain shift chain for the asynchronous ack level; nothing between stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGE-2:0], ack_in};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGE-1];

  // s_ready comes from the state register only, so accept has no s_valid->s_ready loop
  assign accept = s_valid & s_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: launch on accept, return once the synchronized ack matches req
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)              state_nxt = ST_WAIT;
      ST_WAIT: if (ack_sync == req_out) state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_IDLE: s_ready = 1'b1;
      ST_WAIT: busy    = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // Launch register and request toggle move together on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_out  <= 1'b0;
      data_out <= '0;
    end else if (accept) begin
      req_out  <= ~req_out;
      data_out <= s_data;
    end
  end

  // Sticky flag: ack level disagrees with req while nothing is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (state == ST_IDLE && ack_sync != req_out) begin
      proto_err <= 1'b1;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts WAIT cycles, saturates at the limit; the flag fires on the edge that reaches it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT && tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (tmo_cnt == TMO_LAST) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - scoreboard bench for cdc_handshake_tx
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        req_out;
  logic [31:0] data_out;
  logic        ack_in;
  logic        busy;
  logic        proto_err;
  logic        timeout_err;

  // 0: zero-delay loopback, 1: 20-cycle delayed echo, 2: forced level
  int          ack_mode = 0;
  logic        ack_force = 1'b0;
  logic [19:0] dly = '0;

  typedef struct packed {
    logic        req;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   cyc = 0;
  logic req_model = 1'b0;
  logic last_req = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign ack_in = (ack_mode == 0) ? req_out : (ack_mode == 1) ? dly[19] : ack_force;

  always @(posedge clk) dly <= {dly[18:0], req_out};

  cdc_handshake_tx #(
    .DATA_WIDTH    (32),
    .SYNC_STAGE    (3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_in     (ack_in),
    .busy       (busy),
    .proto_err  (proto_err),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Push expectations at every accepting edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      req_model = 1'b0;
    end else if (s_valid && s_ready) begin
      req_model = ~req_model;
      exp_q.push_back('{req: req_model, data: s_data});
      acc_cyc.push_back(cyc);
    end
  end

  // Pop and compare whenever the request level moves
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_req = req_out;
    end else if (req_out !== last_req) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_toggle", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_req", {31'd0, req_out}, {31'd0, e.req});
        chk("sb_data", data_out, e.data);
      end
      last_req = req_out;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pulse(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] words [3];
    int idx;
    int guard;
    int base;
    logic found;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, req_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_req_after", {31'd0, req_out}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_busy_after", {31'd0, busy}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);

    // Loopback single transfer
    ack_mode = 0;
    send_pulse(32'hA5A5_0001);
    chk("lb_data", data_out, 32'hA5A5_0001);
    chk("lb_req", {31'd0, req_out}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("lb_busy", {31'd0, busy}, 32'd1);
      chk("lb_not_ready", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
    end
    chk("lb_ready_c5", {31'd0, s_ready}, 32'd1);

    // Back-to-back from reset
    do_reset();
    words[0] = 32'h0000_0001;
    words[1] = 32'h0000_0002;
    words[2] = 32'h0000_0003;
    base = acc_cyc.size();
    idx = 0;
    guard = 0;
    s_valid = 1'b1;
    s_data = words[0];
    while (idx < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (acc_cyc.size() > base + idx) begin
        idx++;
        if (idx < 3) s_data = words[idx];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    chk("b2b_count", acc_cyc.size() - base, 32'd3);
    if (acc_cyc.size() >= base + 3) begin
      chk("b2b_gap1", acc_cyc[base+1] - acc_cyc[base], 32'd5);
      chk("b2b_gap2", acc_cyc[base+2] - acc_cyc[base+1], 32'd5);
    end
    repeat (6) @(negedge clk);
    chk("b2b_final_req", {31'd0, req_out}, 32'd1);

    // Delayed ack: let the delay line settle on the current req level first
    repeat (25) @(negedge clk);
    ack_mode = 1;
    send_pulse(32'h0000_BEEF);
    for (int i = 0; i < 24; i++) begin
      chk("dly_hold_data", data_out, 32'h0000_BEEF);
      chk("dly_not_ready", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
    end
    chk("dly_ready", {31'd0, s_ready}, 32'd1);
    chk("dly_no_perr", {31'd0, proto_err}, 32'd0);

    // Protocol error in IDLE with req_out = 0
    ack_mode = 2;
    ack_force = 1'b0;
    do_reset();
    ack_force = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (proto_err) begin
        found = 1'b1;
        break;
      end
    end
    chk("perr_set", {31'd0, found}, 32'd1);
    repeat (2) @(negedge clk);
    ack_force = 1'b0;
    repeat (10) @(negedge clk);
    chk("perr_sticky", {31'd0, proto_err}, 32'd1);
    chk("perr_idle", {31'd0, s_ready}, 32'd1);
    chk("perr_req", {31'd0, req_out}, 32'd0);

    // Timeout: ack never returns
    do_reset();
    chk("perr_cleared", {31'd0, proto_err}, 32'd0);
    send_pulse(32'h0000_7777);
    repeat (15) @(negedge clk);
    chk("tmo_before", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
`ifdef CDC_TX_TIMEOUT_EN
    chk("tmo_set", {31'd0, timeout_err}, 32'd1);
`else
    chk("tmo_off", {31'd0, timeout_err}, 32'd0);
`endif
    chk("tmo_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-transfer
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, req_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", data_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("mid_rst_perr", {31'd0, proto_err}, 32'd0);
    chk("mid_rst_terr", {31'd0, timeout_err}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
